// File: rtl/mux_pkg.sv
// Shared definitions for the scanning word multiplexer.
//   state_t     : sequencer state encoding
//   MODE_MANUAL : mode input value that selects the external channel select
//   MODE_SCAN   : mode input value that selects the internal scan sequencer
package mux_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    MANUAL     = 2'd1,
    SCAN_DWELL = 2'd2,
    SCAN_STALL = 2'd3
  } state_t;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/mux_sel_n.sv
// Combinational N:1 word selector.
//   din  : NCH packed channels, channel k at din[k*W +: W]
//   sel  : channel index
//   dout : selected channel word, 0 when sel is out of range
//   oob  : 1 when sel >= NCH
module mux_sel_n #(
  parameter  int NCH  = 16,
  parameter  int W    = 8,
  localparam int SELW = $clog2(NCH)
) (
  input  logic [NCH*W-1:0] din,
  input  logic [SELW-1:0]  sel,
  output logic [W-1:0]     dout,
  output logic             oob
);

  // A compare per channel keeps the index arithmetic free of width
  // concerns; no channel matching means the select is out of range.
  always_comb begin
    dout = '0;
    oob  = 1'b1;
    for (int k = 0; k < NCH; k++) begin
      if (sel == SELW'(k)) begin
        dout = din[k*W +: W];
        oob  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_scan_n.sv
// Registered N:1 word multiplexer with manual select and a dwell-timed scan
// sequencer, driving a valid/ready output slot.
//   clk, rst_n : clock, synchronous active-low reset
//   din        : NCH packed channels of W bits
//   enable     : 1 = sampling allowed, 0 = go idle
//   mode       : 0 = manual (sel_in), 1 = scan
//   sel_in     : manual channel index
//   dwell      : scan cycles per channel (0 behaves as 1)
//   out_ready  : downstream accepts dout this cycle
//   out_valid  : dout/ch_out hold a sample
//   dout       : sampled data
//   ch_out     : index of the sampled channel
//   wrap       : pulse when the scan pointer wraps NCH-1 -> 0
//   sel_err    : pulse on a manual capture with sel_in >= NCH
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | no captures; waits for enable, then picks mode
// MANUAL     | capture din[sel_in] whenever the output slot is free
// SCAN_DWELL | count dwell cycles, capture din[ptr] at terminal count
// SCAN_STALL | terminal count reached with the slot busy; counters frozen
module mux_scan_n
  import mux_pkg::*;
#(
  parameter  int NCH     = 16,
  parameter  int W       = 8,
  parameter  int DWELL_W = 8,
  localparam int SELW    = $clog2(NCH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NCH*W-1:0]   din,
  input  logic               enable,
  input  logic               mode,
  input  logic [SELW-1:0]    sel_in,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [W-1:0]       dout,
  output logic [SELW-1:0]    ch_out,
  output logic               wrap,
  output logic               sel_err
);

  state_t             state, state_d;
  logic [SELW-1:0]    ptr, ptr_d;
  logic [DWELL_W-1:0] dwell_cnt, cnt_d;
  logic               wrap_d, sel_err_d;
  logic               capture;
  logic               slot_free;
  logic               dwell_tc;
  logic [DWELL_W-1:0] dwell_last;
  logic [SELW-1:0]    sel_idx;
  logic [W-1:0]       sel_dout;
  logic               sel_oob;

  assign slot_free  = !out_valid || out_ready;
  // dwell of 0 behaves as 1, so its terminal count is 0 as well
  assign dwell_last = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
  assign dwell_tc   = (dwell_cnt == dwell_last);
  assign sel_idx    = (state == MANUAL) ? sel_in : ptr;

  mux_sel_n #(
    .NCH (NCH),
    .W   (W)
  ) u_sel (
    .din  (din),
    .sel  (sel_idx),
    .dout (sel_dout),
    .oob  (sel_oob)
  );

  always_comb begin
    state_d   = state;
    ptr_d     = ptr;
    cnt_d     = dwell_cnt;
    capture   = 1'b0;
    wrap_d    = 1'b0;
    sel_err_d = 1'b0;

    case (state)
      IDLE: begin
        if (enable) begin
          if (mode == MODE_MANUAL) begin
            state_d = MANUAL;
          end else begin
            state_d = SCAN_DWELL;
            ptr_d   = '0;
            cnt_d   = '0;
          end
        end
      end

      MANUAL: begin
        // a mode change passes through IDLE so scans restart at channel 0
        if (!enable || mode != MODE_MANUAL) begin
          state_d = IDLE;
        end else if (slot_free) begin
          capture   = 1'b1;
          sel_err_d = sel_oob;
        end
      end

      SCAN_DWELL, SCAN_STALL: begin
        if (!enable || mode != MODE_SCAN) begin
          state_d = IDLE;
        end else if (state == SCAN_STALL || dwell_tc) begin
          if (slot_free) begin
            capture = 1'b1;
            state_d = SCAN_DWELL;
            cnt_d   = '0;
            if (ptr == SELW'(NCH-1)) begin
              ptr_d  = '0;
              wrap_d = 1'b1;
            end else begin
              ptr_d = ptr + SELW'(1);
            end
          end else begin
            state_d = SCAN_STALL;
          end
        end else begin
          cnt_d = dwell_cnt + DWELL_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      dwell_cnt <= '0;
      out_valid <= 1'b0;
      dout      <= '0;
      ch_out    <= '0;
      wrap      <= 1'b0;
      sel_err   <= 1'b0;
    end else begin
      state     <= state_d;
      ptr       <= ptr_d;
      dwell_cnt <= cnt_d;
      wrap      <= wrap_d;
      sel_err   <= sel_err_d;
      if (capture) begin
        out_valid <= 1'b1;
        dout      <= sel_dout;
        ch_out    <= sel_idx;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_scan_n.sv
// Directed bench for mux_scan_n: a 16-channel instance for the main
// behaviour and a 12-channel instance for out-of-range manual selects.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mux_scan_n;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] din16;
  logic [95:0]  din12;
  logic         enable;
  logic         mode;
  logic [3:0]   sel_in;
  logic [7:0]   dwell;
  logic         out_ready;

  logic         out_valid, wrap, sel_err;
  logic [7:0]   dout;
  logic [3:0]   ch_out;
  logic         out_valid12, wrap12, sel_err12;
  logic [7:0]   dout12;
  logic [3:0]   ch_out12;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mux_scan_n #(.NCH(16), .W(8), .DWELL_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .din(din16), .enable(enable), .mode(mode),
    .sel_in(sel_in), .dwell(dwell), .out_ready(out_ready),
    .out_valid(out_valid), .dout(dout), .ch_out(ch_out),
    .wrap(wrap), .sel_err(sel_err)
  );

  mux_scan_n #(.NCH(12), .W(8), .DWELL_W(8)) dut12 (
    .clk(clk), .rst_n(rst_n), .din(din12), .enable(enable), .mode(mode),
    .sel_in(sel_in), .dwell(dwell), .out_ready(out_ready),
    .out_valid(out_valid12), .dout(dout12), .ch_out(ch_out12),
    .wrap(wrap12), .sel_err(sel_err12)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) step();
    checks++;
    if (out_valid !== 1'b0 || dout !== 8'h00 || ch_out !== 4'd0 ||
        wrap !== 1'b0 || sel_err !== 1'b0) begin
      errors++;
      $display("FAIL reset: got v=%b d=%h ch=%0d w=%b e=%b exp all 0",
               out_valid, dout, ch_out, wrap, sel_err);
    end
    rst_n  = 1'b1;
    enable = 1'b0;
    step();
  endtask

  task automatic test_manual();
    mode = 1'b0; sel_in = 4'd5; out_ready = 1'b1; enable = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL manual_entry: got v=%b exp 0", out_valid);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || dout !== 8'h15 || ch_out !== 4'd5 || sel_err !== 1'b0) begin
      errors++;
      $display("FAIL manual_sel5: got v=%b d=%h ch=%0d e=%b exp v=1 d=15 ch=5 e=0",
               out_valid, dout, ch_out, sel_err);
    end
    sel_in = 4'd9;
    step();
    checks++;
    if (out_valid !== 1'b1 || dout !== 8'h19 || ch_out !== 4'd9) begin
      errors++;
      $display("FAIL manual_sel9: got v=%b d=%h ch=%0d exp v=1 d=19 ch=9",
               out_valid, dout, ch_out);
    end
    enable = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL manual_disable: got v=%b exp 0", out_valid);
    end
    step();
  endtask

  task automatic test_scan();
    logic [3:0] exp_ch;
    mode = 1'b1; dwell = 8'd3; out_ready = 1'b1; enable = 1'b1;
    step();
    for (int i = 0; i < 17; i++) begin
      for (int j = 0; j < 2; j++) begin
        step();
        checks++;
        if (out_valid !== 1'b0 || wrap !== 1'b0) begin
          errors++;
          $display("FAIL scan3_gap: sample %0d got v=%b w=%b exp v=0 w=0", i, out_valid, wrap);
        end
      end
      step();
      exp_ch = 4'(i % 16);
      checks++;
      if (out_valid !== 1'b1 || ch_out !== exp_ch || dout !== (8'h10 + 8'(exp_ch)) ||
          wrap !== (i == 15)) begin
        errors++;
        $display("FAIL scan3_sample: got v=%b ch=%0d d=%h w=%b exp v=1 ch=%0d d=%h w=%b",
                 out_valid, ch_out, dout, wrap, exp_ch, 8'h10 + 8'(exp_ch), (i == 15));
      end
    end
    enable = 1'b0;
    step(); step();
    dwell = 8'd0; enable = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || ch_out !== 4'(i) || dout !== (8'h10 + 8'(i))) begin
        errors++;
        $display("FAIL scan0_sample: got v=%b ch=%0d d=%h exp v=1 ch=%0d d=%h",
                 out_valid, ch_out, dout, i, 8'h10 + 8'(i));
      end
    end
    enable = 1'b0;
    step(); step();
  endtask

  task automatic test_stall();
    mode = 1'b1; dwell = 8'd2; out_ready = 1'b1; enable = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      step(); step();
      checks++;
      if (out_valid !== 1'b1 || ch_out !== 4'(i)) begin
        errors++;
        $display("FAIL stall_pre: got v=%b ch=%0d exp v=1 ch=%0d", out_valid, ch_out, i);
      end
    end
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || dout !== 8'h14 || ch_out !== 4'd4) begin
        errors++;
        $display("FAIL stall_hold: cycle %0d got v=%b d=%h ch=%0d exp v=1 d=14 ch=4",
                 i, out_valid, dout, ch_out);
      end
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b1 || dout !== 8'h15 || ch_out !== 4'd5) begin
      errors++;
      $display("FAIL stall_release: got v=%b d=%h ch=%0d exp v=1 d=15 ch=5",
               out_valid, dout, ch_out);
    end
    step(); step();
    checks++;
    if (out_valid !== 1'b1 || dout !== 8'h16 || ch_out !== 4'd6) begin
      errors++;
      $display("FAIL stall_next: got v=%b d=%h ch=%0d exp v=1 d=16 ch=6",
               out_valid, dout, ch_out);
    end
    out_ready = 1'b0;
    repeat (4) step();
    rst_n = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0 || ch_out !== 4'd0 || dout !== 8'h00) begin
      errors++;
      $display("FAIL reset_stalled: got v=%b d=%h ch=%0d exp v=0 d=00 ch=0",
               out_valid, dout, ch_out);
    end
    rst_n = 1'b1; enable = 1'b0; out_ready = 1'b1;
    step();
  endtask

  task automatic test_mode_enable();
    mode = 1'b1; dwell = 8'd1; out_ready = 1'b1; enable = 1'b1;
    step();
    for (int i = 0; i < 7; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || ch_out !== 4'(i)) begin
        errors++;
        $display("FAIL mode_prescan: got v=%b ch=%0d exp v=1 ch=%0d", out_valid, ch_out, i);
      end
    end
    mode = 1'b0; sel_in = 4'd3;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL mode_to_manual_gap: cycle %0d got v=%b exp 0", i, out_valid);
      end
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || ch_out !== 4'd3 || dout !== 8'h13) begin
      errors++;
      $display("FAIL mode_manual: got v=%b ch=%0d d=%h exp v=1 ch=3 d=13",
               out_valid, ch_out, dout);
    end
    mode = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL mode_to_scan_gap: cycle %0d got v=%b exp 0", i, out_valid);
      end
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || ch_out !== 4'd0 || dout !== 8'h10) begin
      errors++;
      $display("FAIL mode_rescan: got v=%b ch=%0d d=%h exp v=1 ch=0 d=10",
               out_valid, ch_out, dout);
    end
    out_ready = 1'b0; enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || ch_out !== 4'd0 || dout !== 8'h10) begin
        errors++;
        $display("FAIL disable_hold: cycle %0d got v=%b ch=%0d d=%h exp v=1 ch=0 d=10",
                 i, out_valid, ch_out, dout);
      end
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL disable_drain: got v=%b exp 0", out_valid);
    end
    step();
  endtask

  task automatic test_sel_err();
    mode = 1'b0; sel_in = 4'd11; out_ready = 1'b1; enable = 1'b1;
    step();
    step();
    checks++;
    if (out_valid12 !== 1'b1 || dout12 !== 8'h1B || ch_out12 !== 4'd11 || sel_err12 !== 1'b0) begin
      errors++;
      $display("FAIL sel_last: got v=%b d=%h ch=%0d e=%b exp v=1 d=1b ch=11 e=0",
               out_valid12, dout12, ch_out12, sel_err12);
    end
    sel_in = 4'd13;
    step();
    checks++;
    if (out_valid12 !== 1'b1 || dout12 !== 8'h00 || ch_out12 !== 4'd13 || sel_err12 !== 1'b1) begin
      errors++;
      $display("FAIL sel_oob: got v=%b d=%h ch=%0d e=%b exp v=1 d=00 ch=13 e=1",
               out_valid12, dout12, ch_out12, sel_err12);
    end
    checks++;
    if (dout !== 8'h1D || sel_err !== 1'b0) begin
      errors++;
      $display("FAIL sel13_in_range16: got d=%h e=%b exp d=1d e=0", dout, sel_err);
    end
    sel_in = 4'd2;
    step();
    checks++;
    if (out_valid12 !== 1'b1 || dout12 !== 8'h12 || ch_out12 !== 4'd2 || sel_err12 !== 1'b0) begin
      errors++;
      $display("FAIL sel_err_pulse: got v=%b d=%h ch=%0d e=%b exp v=1 d=12 ch=2 e=0",
               out_valid12, dout12, ch_out12, sel_err12);
    end
    enable = 1'b0;
    step();
  endtask

  initial begin
    for (int k = 0; k < 16; k++) din16[k*8 +: 8] = 8'h10 + 8'(k);
    for (int k = 0; k < 12; k++) din12[k*8 +: 8] = 8'h10 + 8'(k);
    rst_n     = 1'b0;
    enable    = 1'b1;
    mode      = 1'b0;
    sel_in    = 4'd0;
    dwell     = 8'd1;
    out_ready = 1'b1;

    test_reset();
    test_manual();
    test_scan();
    test_stall();
    test_mode_enable();
    test_sel_err();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
